// File: rtl/formation_pkg.sv
// Shared types and fixed-point constants for the invader formation mover.
package formation_pkg;

  localparam int FRAC_BITS = 6;
  localparam int FP_W      = 18;

  typedef enum logic [1:0] {
    StMarch,
    StDescend,
    StHalt
  } state_e;

endpackage

// File: rtl/alive_extent.sv
// Lowest and highest occupied column of the formation, plus an all-dead flag.
module alive_extent #(
  parameter int COLS  = 10,
  parameter int IDX_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [COLS-1:0]  alive,
  output logic [IDX_W-1:0] left_idx,
  output logic [IDX_W-1:0] right_idx,
  output logic             empty
);

  // Scanning in opposite directions lets the last hit win in each loop.
  always_comb begin
    left_idx  = '0;
    right_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (alive[i]) left_idx = IDX_W'(i);
    end
    for (int i = 0; i < COLS; i++) begin
      if (alive[i]) right_idx = IDX_W'(i);
    end
  end

  assign empty = ~|alive;

endmodule

// File: rtl/formation_mover.sv
// Moves the invader formation: marches sideways, bounces off the margins, drops a row,
// and halts when it lands or when every column is dead.
module formation_mover
  import formation_pkg::*;
#(
  parameter int COLS       = 10,
  parameter int COL_W      = 32,
  parameter int SCREEN_W   = 640,
  parameter int MARGIN     = 32,
  parameter int INIT_X     = 33,
  parameter int INIT_Y     = 32,
  parameter int INIT_SPEED = 15,
  parameter int SPEED_INC  = 5,
  parameter int MAX_SPEED  = 255,
  parameter int DROP_Y     = 32,
  parameter int BOTTOM_Y   = 400
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               restart,
  input  logic [COLS-1:0]    alive_cols,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               dir_right,
  output logic               descend,
  output logic               reached_bottom,
  output logic               empty
);

  localparam int IDX_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int EXT_W  = FP_W + 6;
  localparam int ONE_PX = 1 << FRAC_BITS;

  localparam logic signed [FP_W-1:0]  InitXFp  = FP_W'(INIT_X * ONE_PX);
  localparam logic signed [FP_W-1:0]  InitYFp  = FP_W'(INIT_Y * ONE_PX);
  localparam logic signed [FP_W-1:0]  DropFp   = FP_W'(DROP_Y * ONE_PX);
  localparam logic signed [FP_W-1:0]  BottomFp = FP_W'(BOTTOM_Y * ONE_PX);
  localparam logic signed [EXT_W-1:0] RightLim = EXT_W'((SCREEN_W - MARGIN) * ONE_PX);
  localparam logic signed [EXT_W-1:0] LeftLim  = EXT_W'(MARGIN * ONE_PX);

  state_e                  state_q, state_d;
  logic signed [FP_W-1:0]  x_q, x_d, y_q, y_d;
  logic [8:0]              speed_q, speed_d;
  logic                    dir_q, dir_d;
  logic                    descend_q, descend_d;
  logic                    landed_q, landed_d;

  logic [IDX_W-1:0]        left_idx, right_idx;
  logic                    all_dead;
  logic                    frame_ok;
  logic signed [EXT_W-1:0] x_ext, spd_ext, xn, left_off, right_off;
  logic                    hit_edge;
  logic [9:0]              spd_sum;
  logic [8:0]              spd_bounce;
  logic signed [FP_W-1:0]  y_new;
  logic                    at_bottom;

  alive_extent #(
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_extent (
    .alive     (alive_cols),
    .left_idx  (left_idx),
    .right_idx (right_idx),
    .empty     (all_dead)
  );

  assign frame_ok = startOfFrame && enable && !restart;

  assign x_ext     = EXT_W'(x_q);
  assign spd_ext   = EXT_W'(speed_q);
  assign xn        = dir_q ? (x_ext + spd_ext) : (x_ext - spd_ext);
  assign left_off  = EXT_W'(int'(left_idx) * COL_W * ONE_PX);
  assign right_off = EXT_W'((int'(right_idx) + 1) * COL_W * ONE_PX);
  assign hit_edge  = dir_q ? ((xn + right_off) > RightLim) : ((xn + left_off) < LeftLim);

  assign spd_sum    = {1'b0, speed_q} + 10'(SPEED_INC);
  assign spd_bounce = (spd_sum > 10'(MAX_SPEED)) ? 9'(MAX_SPEED) : spd_sum[8:0];

  assign y_new     = y_q + DropFp;
  assign at_bottom = y_new >= BottomFp;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StMarch;
      x_q       <= InitXFp;
      y_q       <= InitYFp;
      speed_q   <= 9'(INIT_SPEED);
      dir_q     <= 1'b1;
      descend_q <= 1'b0;
      landed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      descend_q <= descend_d;
      landed_q  <= landed_d;
    end
  end

  // An empty mask halts immediately, without waiting for a frame; restart overrides all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StMarch:   if (frame_ok && hit_edge) state_d = StDescend;
      StDescend: if (frame_ok) state_d = at_bottom ? StHalt : StMarch;
      StHalt:    state_d = StHalt;
      default:   state_d = StMarch;
    endcase
    if (all_dead) state_d = StHalt;
    if (restart)  state_d = StMarch;
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    speed_d   = speed_q;
    dir_d     = dir_q;
    descend_d = 1'b0;
    landed_d  = landed_q;
    if (restart) begin
      x_d      = InitXFp;
      y_d      = InitYFp;
      speed_d  = 9'(INIT_SPEED);
      dir_d    = 1'b1;
      landed_d = 1'b0;
    end else if (frame_ok && !all_dead) begin
      case (state_q)
        StMarch: begin
          if (hit_edge) begin
            dir_d   = !dir_q;
            speed_d = spd_bounce;
          end else begin
            x_d = FP_W'(xn);
          end
        end
        StDescend: begin
          y_d       = y_new;
          descend_d = 1'b1;
          landed_d  = at_bottom;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    topLeftX       = 11'(x_q >>> FRAC_BITS);
    topLeftY       = 11'(y_q >>> FRAC_BITS);
    dir_right      = dir_q;
    descend        = descend_q;
    reached_bottom = (state_q == StHalt) && landed_q;
    empty          = all_dead;
  end

endmodule

// File: tb/tb_formation_mover.sv
// Directed bench: a table of march segments plus hand sequences for reset-in-descend and empty.
module tb_formation_mover;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               enable;
  logic               restart;
  logic [9:0]         alive_cols;
  logic signed [10:0] topLeftX, topLeftY, b_x, b_y;
  logic               dir_right, descend, reached_bottom, empty;
  logic               b_dir, b_descend, b_reached, b_empty;

  int checks = 0;
  int errors = 0;
  int desc_cnt = 0;
  int desc_b = 0;

  always #5 clk = ~clk;

  formation_mover dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .restart        (restart),
    .alive_cols     (alive_cols),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .dir_right      (dir_right),
    .descend        (descend),
    .reached_bottom (reached_bottom),
    .empty          (empty)
  );

  formation_mover #(
    .BOTTOM_Y (96)
  ) dut_b (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .restart        (restart),
    .alive_cols     (alive_cols),
    .topLeftX       (b_x),
    .topLeftY       (b_y),
    .dir_right      (b_dir),
    .descend        (b_descend),
    .reached_bottom (b_reached),
    .empty          (b_empty)
  );

  always @(negedge clk) begin
    if (descend) desc_cnt++;
    if (b_descend) desc_b++;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [9:0] alive;
    int         n;
    int         ex;
    int         ey;
    logic       edir;
    int         edesc;
    int         ebx;
    logic       erb;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_restart();
    restart      = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    restart      = 1'b0;
    startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //            rst   en    alive   n     x     y   dir  desc  bx    rb_b
    vecs[0]  = '{1'b0, 1'b1, 10'h3FF, 0,    33,   32, 1'b1, 0,   33,   1'b0};
    vecs[1]  = '{1'b0, 1'b1, 10'h3FF, 64,   48,   32, 1'b1, 0,   48,   1'b0};
    vecs[2]  = '{1'b0, 1'b0, 10'h3FF, 10,   48,   32, 1'b1, 0,   48,   1'b0};
    vecs[3]  = '{1'b0, 1'b1, 10'h3FF, 1024, 288,  32, 1'b1, 0,   288,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, 10'h3FF, 1,    288,  32, 1'b0, 0,   288,  1'b0};
    vecs[5]  = '{1'b0, 1'b1, 10'h3FF, 1,    288,  64, 1'b0, 1,   288,  1'b0};
    vecs[6]  = '{1'b0, 1'b1, 10'h3FF, 64,   268,  64, 1'b0, 1,   268,  1'b0};
    vecs[7]  = '{1'b0, 1'b1, 10'h3FF, 755,  32,   64, 1'b0, 1,   32,   1'b0};
    vecs[8]  = '{1'b0, 1'b1, 10'h3FF, 1,    32,   64, 1'b1, 1,   32,   1'b0};
    vecs[9]  = '{1'b0, 1'b1, 10'h3FF, 1,    32,   96, 1'b1, 2,   32,   1'b1};
    vecs[10] = '{1'b0, 1'b1, 10'h3FF, 10,   35,   96, 1'b1, 2,   32,   1'b1};
    vecs[11] = '{1'b1, 1'b1, 10'h003, 0,    33,   32, 1'b1, 2,   33,   1'b0};
    vecs[12] = '{1'b0, 1'b1, 10'h003, 2180, 543,  32, 1'b1, 2,   543,  1'b0};
    vecs[13] = '{1'b0, 1'b1, 10'h003, 1,    543,  32, 1'b0, 2,   543,  1'b0};
    vecs[14] = '{1'b0, 1'b1, 10'h003, 1,    543,  64, 1'b0, 3,   543,  1'b0};
    vecs[15] = '{1'b0, 1'b1, 10'h300, 2457, -224, 64, 1'b0, 3,   -224, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 10'h300, 1,    -224, 64, 1'b1, 3,   -224, 1'b0};

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    enable       = 1'b1;
    restart      = 1'b0;
    alive_cols   = 10'h3FF;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      alive_cols = vecs[i].alive;
      enable     = vecs[i].en;
      if (vecs[i].rst) do_restart();
      for (int k = 0; k < vecs[i].n; k++) frame();
      #1;
      chk($sformatf("row%0d x", i), int'(topLeftX), vecs[i].ex);
      chk($sformatf("row%0d y", i), int'(topLeftY), vecs[i].ey);
      chk($sformatf("row%0d dir", i), int'(dir_right), int'(vecs[i].edir));
      chk($sformatf("row%0d descends", i), desc_cnt, vecs[i].edesc);
      chk($sformatf("row%0d reached", i), int'(reached_bottom), 0);
      chk($sformatf("row%0d empty", i), int'(empty), 0);
      chk($sformatf("row%0d b_x", i), int'(b_x), vecs[i].ebx);
      chk($sformatf("row%0d b_reached", i), int'(b_reached), int'(vecs[i].erb));
      chk($sformatf("row%0d b_empty", i), int'(b_empty), 0);
      if (i == 10) begin
        chk("landed b_y", int'(b_y), 96);
        chk("landed b_dir", int'(b_dir), 1);
        chk("landed b_descends", desc_b, 2);
      end
    end

    // Reset while waiting to drop: the drop must be abandoned.
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("rst x", int'(topLeftX), 33);
    chk("rst y", int'(topLeftY), 32);
    chk("rst dir", int'(dir_right), 1);
    @(negedge clk);
    resetN     = 1'b1;
    alive_cols = 10'h3FF;
    enable     = 1'b1;
    frame();
    #1;
    chk("post-rst y", int'(topLeftY), 32);
    chk("post-rst descends", desc_cnt, 3);
    for (int k = 0; k < 63; k++) frame();
    #1;
    chk("post-rst x speed", int'(topLeftX), 48);
    chk("post-rst dir", int'(dir_right), 1);

    // Empty mask halts on the next edge, even with no frame pulse.
    alive_cols = 10'h000;
    #1;
    chk("empty flag", int'(empty), 1);
    @(negedge clk);
    alive_cols = 10'h3FF;
    for (int k = 0; k < 5; k++) frame();
    #1;
    chk("empty halt x", int'(topLeftX), 48);
    chk("empty halt reached", int'(reached_bottom), 0);
    chk("empty cleared", int'(empty), 0);
    chk("empty descends", desc_cnt, 3);
    do_restart();
    for (int k = 0; k < 64; k++) frame();
    #1;
    chk("restart after halt x", int'(topLeftX), 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
